// File: rtl/piso_transmitter_pkg.sv
// Shared types and constants for the PISO serial transmitter.
// State encoding, idle line level and counter sizing helper.
package piso_transmitter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10,
    DONE   = 2'b11
  } tx_state_e;

  localparam logic IDLE_LEVEL = 1'b0;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_transmitter_if.sv
// Load handshake and serial line bundle between control logic and the transmitter.
// Master drives data/load; slave returns ready and the registered serial outputs.
interface piso_transmitter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_tx;
  logic             load_tx;
  logic             ready_tx;
  logic             serial_tx;
  logic             frame_tx;
  logic             done_tx;

  modport master (
    output data_tx, load_tx,
    input  ready_tx, serial_tx, frame_tx, done_tx
  );

  modport slave (
    input  data_tx, load_tx,
    output ready_tx, serial_tx, frame_tx, done_tx
  );
endinterface

// File: rtl/piso_transmitter_tx_bit_counter.sv
// Bit index counter for the word on the line; clr restarts at 0, en advances by one.
// Single-cycle update, tc is combinational from the count; no backpressure.
module tx_bit_counter
  import piso_transmitter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk_tx,
  input  logic rst_n_tx,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] count;

  always_ff @(posedge clk_tx) begin
    if (!rst_n_tx) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_transmitter.sv
// Parallel-in/serial-out transmitter: first bit on the line one edge after load, word period WIDTH+PARITY_EN+1.
// ready_tx is high only in IDLE; loads while busy are dropped, never queued.
module piso_transmitter
  import piso_transmitter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic clk_tx,
  input  logic rst_n_tx,
  piso_transmitter_if.slave link
);
  tx_state_e        state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic             par, par_nxt;
  logic             serial, serial_nxt;
  logic             frame, frame_nxt;
  logic             done, done_nxt;
  logic             ready, ready_nxt;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic             ld_head, sh_head;
  logic [WIDTH-1:0] ld_rest, sh_rest;

  // sreg holds only the bits not yet sent, aligned so the next one sits at the send end
  always_comb begin
    ld_head = MSB_FIRST ? link.data_tx[WIDTH-1] : link.data_tx[0];
    ld_rest = MSB_FIRST ? {link.data_tx[WIDTH-2:0], 1'b0} : {1'b0, link.data_tx[WIDTH-1:1]};
    sh_head = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    sh_rest = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
  end

  always_comb begin
    state_nxt  = state;
    sreg_nxt   = sreg;
    par_nxt    = par;
    serial_nxt = IDLE_LEVEL;
    frame_nxt  = 1'b0;
    done_nxt   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      IDLE: begin
        if (link.load_tx) begin
          state_nxt  = SHIFT;
          sreg_nxt   = ld_rest;
          par_nxt    = ld_head;
          serial_nxt = ld_head;
          frame_nxt  = 1'b1;
          cnt_clr    = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_tc) begin
          if (PARITY_EN) begin
            state_nxt  = PARITY;
            serial_nxt = par;
            frame_nxt  = 1'b1;
          end else begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end
        end else begin
          sreg_nxt   = sh_rest;
          par_nxt    = par ^ sh_head;
          serial_nxt = sh_head;
          frame_nxt  = 1'b1;
          cnt_en     = 1'b1;
        end
      end
      PARITY: begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    ready_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge clk_tx) begin
    if (!rst_n_tx) begin
      state  <= IDLE;
      sreg   <= '0;
      par    <= 1'b0;
      serial <= IDLE_LEVEL;
      frame  <= 1'b0;
      done   <= 1'b0;
      ready  <= 1'b1;
    end else begin
      state  <= state_nxt;
      sreg   <= sreg_nxt;
      par    <= par_nxt;
      serial <= serial_nxt;
      frame  <= frame_nxt;
      done   <= done_nxt;
      ready  <= ready_nxt;
    end
  end

  tx_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk_tx  (clk_tx),
    .rst_n_tx(rst_n_tx),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .tc      (cnt_tc)
  );

  assign link.ready_tx  = ready;
  assign link.serial_tx = serial;
  assign link.frame_tx  = frame;
  assign link.done_tx   = done;

endmodule
